bally_cart_loader: RTL and testbench

- Sits between the hps_io ioctl download stream and the 8 KB cartridge dpram, and between that dpram and the BALLY core cart port.
- Captures a BIN cart image and records its size.
- After the download ends, it pads the unwritten region with a fill byte. It then serves core reads, mirroring 2 KB and 4 KB images across the 8 KB window.
- Owns the dpram port A address, data and write-enable muxing.

---
 rtl/bally_pkg.sv | 18 +
 rtl/bally_cart_loader.sv | 110 +++++++++++
 tb/tb_bally_cart_loader.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/bally_pkg.sv
// Shared types and constants for the Bally cartridge loader.
package bally_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, FILL, READY} cart_ld_state_t;

  localparam int          CART_MAX = 8192;
  localparam logic [12:0] MASK_2K  = 13'h07FF;
  localparam logic [12:0] MASK_4K  = 13'h0FFF;
  localparam logic [12:0] MASK_8K  = 13'h1FFF;

  // Smallest power-of-two window that holds the image; empty or large images use the full window.
  function automatic logic [12:0] mirror_mask(input logic [13:0] size);
    if (size != 14'd0 && size <= 14'd2048) return MASK_2K;
    if (size > 14'd2048 && size <= 14'd4096) return MASK_4K;
    return MASK_8K;
  endfunction

endpackage

// File: rtl/bally_cart_loader.sv
// Cart image loader: captures ioctl BIN download, pads with fill byte, serves core reads.
// Define BALLY_CART_MIRROR_EN to mirror 2 KB / 4 KB images across the 8 KB window.
module bally_cart_loader
  import bally_pkg::*;
#(
  parameter int          ADDR_W     = 13,
  parameter logic [7:0]  LOAD_INDEX = 8'd1,
  parameter logic [7:0]  FILL_BYTE  = 8'hFF
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [7:0]        cpu_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              ram_we,
  input  logic [7:0]        ram_q,
  output logic [ADDR_W:0]   cart_size,
  output logic              busy,
  output logic              overflow
);

  localparam int               SIZE_W = ADDR_W + 1;
  localparam logic [SIZE_W-1:0] WIN   = SIZE_W'(1) << ADDR_W;

  cart_ld_state_t    state, state_nxt;
  logic              dl_d;
  logic              rd_valid;
  logic [SIZE_W-1:0] fill_ptr;
  logic [SIZE_W-1:0] wr_end;
  logic [ADDR_W-1:0] ready_mask, rd_mask;
  logic              dl_rise, dl_fall, in_win, fill_done, fill_last;

  assign dl_rise   = ioctl_download & ~dl_d & (ioctl_index == LOAD_INDEX);
  assign dl_fall   = ~ioctl_download & dl_d;
  assign in_win    = (ioctl_addr[24:ADDR_W] == '0);
  assign wr_end    = SIZE_W'({1'b0, ioctl_addr[ADDR_W-1:0]}) + SIZE_W'(1);
  assign fill_done = (fill_ptr == WIN);
  assign fill_last = (fill_ptr == WIN - SIZE_W'(1));

`ifdef BALLY_CART_MIRROR_EN
  assign ready_mask = ADDR_W'(mirror_mask(14'(cart_size)));
`else
  assign ready_mask = ADDR_W'(MASK_8K);
`endif
  assign rd_mask = (state == READY) ? ready_mask : '1;

  always_comb begin
    state_nxt = state;
    ram_we    = 1'b0;
    ram_addr  = cpu_addr & rd_mask;
    ram_din   = FILL_BYTE;
    case (state)
      LOAD: begin
        if (ioctl_wr && in_win) begin
          ram_we   = 1'b1;
          ram_addr = ioctl_addr[ADDR_W-1:0];
          ram_din  = ioctl_dout;
        end
        // A full image has nothing to pad, so skip FILL entirely.
        if (dl_fall) state_nxt = (cart_size == WIN) ? READY : FILL;
      end
      FILL: begin
        if (fill_done) begin
          state_nxt = READY;
        end else begin
          ram_we   = 1'b1;
          ram_addr = fill_ptr[ADDR_W-1:0];
          if (fill_last) state_nxt = READY;
        end
      end
      default: ;
    endcase
    if (dl_rise) state_nxt = LOAD;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      dl_d      <= 1'b0;
      rd_valid  <= 1'b0;
      cart_size <= '0;
      overflow  <= 1'b0;
      fill_ptr  <= '0;
    end else begin
      state    <= state_nxt;
      dl_d     <= ioctl_download;
      rd_valid <= (state == READY);
      if (dl_rise) begin
        cart_size <= '0;
        overflow  <= 1'b0;
      end else if (state == LOAD && ioctl_wr) begin
        if (!in_win)               overflow  <= 1'b1;
        else if (wr_end > cart_size) cart_size <= wr_end;
      end
      // Track size while loading so the pad pointer starts at the image end.
      if (state == LOAD)                  fill_ptr <= cart_size;
      else if (state == FILL && !fill_done) fill_ptr <= fill_ptr + SIZE_W'(1);
    end
  end

  assign busy     = (state == LOAD) || (state == FILL);
  assign cpu_data = rd_valid ? ram_q : FILL_BYTE;

endmodule

// File: tb/tb_bally_cart_loader.sv
// Directed bench for bally_cart_loader with a behavioural 1-cycle-latency dpram.
module tb_bally_cart_loader;
  import bally_pkg::*;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic [12:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic [7:0]  ram_q;
  logic [13:0] cart_size;
  logic        busy;
  logic        overflow;

  logic [7:0] mem [0:8191];
  int errs = 0, checks = 0, we_cnt = 0;
  int n;
  bit mirror;

  bally_cart_loader dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_q(ram_q),
    .cart_size(cart_size), .busy(busy), .overflow(overflow)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_din;
      we_cnt = we_cnt + 1;
    end
    ram_q <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Bytes at addr>=8192 carry a marker so dropped writes would be visible if they aliased.
  task automatic download(input int cnt, input logic [7:0] idx, input bit inv);
    logic [7:0] b;
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick(); tick();
    for (int a = 0; a < cnt; a++) begin
      b = a[7:0];
      if (inv) b = ~b;
      if (a >= 8192) b = 8'h5A;
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(a);
      ioctl_dout = b;
      tick();
    end
    ioctl_wr = 1'b0;
    tick();
    ioctl_download = 1'b0;
    tick();
  endtask

  task automatic fill_wait(output int cyc);
    cyc = 0;
    while (busy && cyc < 10000) begin
      cyc++;
      tick();
    end
  endtask

  task automatic rd(input string tag, input logic [12:0] a, input logic [7:0] exp);
    cpu_addr = a;
    tick();
    chk(tag, cpu_data, exp);
  endtask

  initial begin
`ifdef BALLY_CART_MIRROR_EN
    mirror = 1'b1;
`else
    mirror = 1'b0;
`endif
    reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; cpu_addr = '0;
    tick(); tick();
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    chk("rst_size", cart_size, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_data", cpu_data, 8'hFF);
    reset = 1'b0;
    tick();

    // 2 KB image
    download(2048, 8'd1, 1'b0);
    chk("t1_size", cart_size, 2048);
    chk("t1_state", 32'(dut.state), 32'(FILL));
    chk("t1_fill_we", ram_we, 1);
    chk("t1_fill_addr", ram_addr, 2048);
    chk("t1_fill_din", ram_din, 8'hFF);
    chk("t1_fill_data", cpu_data, 8'hFF);
    fill_wait(n);
    chk("t1_fill_cyc", n, 6144);
    chk("t1_ready", 32'(dut.state), 32'(READY));
    rd("t1_rd805", 13'h0805, mirror ? 8'h05 : 8'hFF);
    rd("t1_rd005", 13'h0005, 8'h05);

    // 3000-byte image
    download(3000, 8'd1, 1'b0);
    chk("t2_size", cart_size, 3000);
    fill_wait(n);
    chk("t2_fill_cyc", n, 5192);
    rd("t2_rdBB7", 13'h0BB7, 8'hB7);
    rd("t2_rdBB8", 13'h0BB8, 8'hFF);
    rd("t2_rd1BB7", 13'h1BB7, mirror ? 8'hB7 : 8'hFF);

    // Oversize image
    download(8200, 8'd1, 1'b0);
    chk("t3_ovf", overflow, 1);
    chk("t3_size", cart_size, 8192);
    chk("t3_state", 32'(dut.state), 32'(READY));
    chk("t3_busy", busy, 0);
    rd("t3_rd1FFF", 13'h1FFF, 8'hFF);
    rd("t3_rd1FFE", 13'h1FFE, 8'hFE);
    rd("t3_rd0003", 13'h0003, 8'h03);

    // Reset during FILL
    download(2048, 8'd1, 1'b0);
    chk("t4_ovf_clr", overflow, 0);
    for (int i = 0; i < 100; i++) tick();
    reset = 1'b1;
    #1;
    chk("t4_state", 32'(dut.state), 32'(IDLE));
    chk("t4_size", cart_size, 0);
    chk("t4_data", cpu_data, 8'hFF);
    chk("t4_busy", busy, 0);
    tick();
    reset = 1'b0;
    tick();
    download(1, 8'd1, 1'b0);
    chk("t4_size1", cart_size, 1);
    fill_wait(n);
    chk("t4_fill_cyc", n, 8191);
    rd("t4_rd0", 13'h0000, 8'h00);
    rd("t4_rd1", 13'h0001, 8'hFF);
    rd("t4_rd800", 13'h0800, mirror ? 8'h00 : 8'hFF);

    // Foreign-index download while READY
    we_cnt = 0;
    download(8192, 8'd0, 1'b1);
    chk("t5_we", we_cnt, 0);
    chk("t5_state", 32'(dut.state), 32'(READY));
    chk("t5_busy", busy, 0);
    chk("t5_size", cart_size, 1);
    rd("t5_rd0", 13'h0000, 8'h00);
    rd("t5_rd1", 13'h0001, 8'hFF);

    // Empty image
    download(0, 8'd1, 1'b0);
    chk("t6_size", cart_size, 0);
    fill_wait(n);
    chk("t6_fill_cyc", n, 8192);
    rd("t6_rd0", 13'h0000, 8'hFF);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
